// File: rtl/line_follow_sequencer.sv
// Run controller for the line follower: arms the motors, gates the PID onto the
// servo path, substitutes a fixed search turn when the line is lost and parks on stop/fault.
module line_follow_sequencer #(
  parameter int unsigned        TICK_DIV        = 100000,
  parameter int unsigned        ARM_MS          = 500,
  parameter int unsigned        LOST_CONFIRM_MS = 20,
  parameter int unsigned        SEARCH_MS       = 2000,
  parameter logic signed [10:0] SEARCH_CMD      = 11'sd300
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [3:0]         sensor,
  input  logic signed [10:0] pid_output,
  output logic signed [10:0] cmd_output,
  output logic               pid_rst,
  output logic               motor_en,
  output logic               fault,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StArm    = 3'd1,
    StFollow = 3'd2,
    StSearch = 3'd3,
    StHalt   = 3'd4
  } state_e;

  localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0]   ARM_LIM    = 16'(ARM_MS);
  localparam logic [15:0]   LOST_LIM   = 16'(LOST_CONFIRM_MS);
  localparam logic [15:0]   SEARCH_LIM = 16'(SEARCH_MS);

  state_e               state_q, state_d;
  logic                 start_q;
  logic                 last_side_q, last_side_d;
  logic [PW-1:0]        presc_q, presc_d, presc_inc;
  logic [15:0]          ms_q, ms_d, ms_inc;
  logic signed [10:0]   cmd_q, cmd_d;
  logic                 motor_en_q, motor_en_d;
  logic                 pid_rst_q, pid_rst_d;
  logic                 fault_q, fault_d;
  logic                 start_edge, line, tick, clear;

  always_comb begin
    start_edge = start & ~start_q;
    line       = |sensor;
    tick       = (presc_q == PRESC_LAST);
    presc_inc  = tick ? '0 : presc_q + PW'(1);
    // Transition thresholds look at the post-tick count so a limit of N ms
    // leaves the state exactly N*TICK_DIV cycles after the counters cleared.
    ms_inc     = (tick && (ms_q != 16'hFFFF)) ? ms_q + 16'd1 : ms_q;

    state_d     = state_q;
    last_side_d = last_side_q;

    case (state_q)
      StIdle:   if (start_edge) state_d = StArm;
      StArm:    if (ms_inc >= ARM_LIM) state_d = StFollow;
      StFollow: if (!line && (ms_inc >= LOST_LIM)) state_d = StSearch;
      StSearch: begin
        if (line) begin
          state_d = StFollow;
        end else if (ms_inc >= SEARCH_LIM) begin
          state_d = StHalt;
        end
      end
      StHalt:   if (start_edge) state_d = StArm;
      default:  state_d = StIdle;
    endcase

    if (stop) state_d = StIdle;

    if ((state_q == StArm) || (state_q == StFollow)) begin
      if (sensor[3] && !sensor[0]) begin
        last_side_d = 1'b0;
      end else if (sensor[0] && !sensor[3]) begin
        last_side_d = 1'b1;
      end
    end

    // In FOLLOW any line sighting restarts the loss confirmation window.
    clear   = stop || (state_d != state_q) || ((state_q == StFollow) && line);
    presc_d = clear ? '0 : presc_inc;
    ms_d    = clear ? '0 : ms_inc;

    cmd_d      = '0;
    motor_en_d = 1'b0;
    pid_rst_d  = 1'b1;
    fault_d    = 1'b0;
    case (state_d)
      StFollow: begin
        cmd_d      = pid_output;
        motor_en_d = 1'b1;
        pid_rst_d  = 1'b0;
      end
      StSearch: begin
        cmd_d      = last_side_d ? SEARCH_CMD : -SEARCH_CMD;
        motor_en_d = 1'b1;
      end
      StHalt:   fault_d = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      last_side_q <= 1'b0;
      presc_q     <= '0;
      ms_q        <= '0;
      cmd_q       <= '0;
      motor_en_q  <= 1'b0;
      pid_rst_q   <= 1'b1;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      last_side_q <= last_side_d;
      presc_q     <= presc_d;
      ms_q        <= ms_d;
      cmd_q       <= cmd_d;
      motor_en_q  <= motor_en_d;
      pid_rst_q   <= pid_rst_d;
      fault_q     <= fault_d;
    end
  end

  assign cmd_output = cmd_q;
  assign motor_en   = motor_en_q;
  assign pid_rst    = pid_rst_q;
  assign fault      = fault_q;
  assign state      = state_q;

endmodule

// File: tb/tb_line_follow_sequencer.sv
// Scoreboard bench for line_follow_sequencer: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_line_follow_sequencer;

  localparam int IDLE   = 0;
  localparam int ARM    = 1;
  localparam int FOLLOW = 2;
  localparam int SEARCH = 3;
  localparam int HALT   = 4;

  logic               clk = 1'b0;
  logic               rst, start, stop;
  logic [3:0]         sensor;
  logic signed [10:0] pid_output;
  logic signed [10:0] cmd_output;
  logic               pid_rst, motor_en, fault;
  logic [2:0]         state;

  line_follow_sequencer #(
    .TICK_DIV       (4),
    .ARM_MS         (3),
    .LOST_CONFIRM_MS(2),
    .SEARCH_MS      (5),
    .SEARCH_CMD     (11'sd300)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .sensor    (sensor),
    .pid_output(pid_output),
    .cmd_output(cmd_output),
    .pid_rst   (pid_rst),
    .motor_en  (motor_en),
    .fault     (fault),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 cyc;
    string              name;
    logic [2:0]         st;
    logic signed [10:0] cmd;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic expect_at(input int c, input string nm, input int st, input int cmd);
    exp_t x;
    x.cyc  = c;
    x.name = nm;
    x.st   = 3'(st);
    x.cmd  = 11'(cmd);
    sb.push_back(x);
  endtask

  // Expected {motor_en, pid_rst, fault} for a given state.
  function automatic logic [2:0] flags_for(input logic [2:0] st);
    flags_for = {(st == 3'(FOLLOW)) || (st == 3'(SEARCH)), st != 3'(FOLLOW), st == 3'(HALT)};
  endfunction

  always @(negedge clk) begin
    while ((sb.size() > 0) && (sb[0].cyc <= cyc)) begin
      e = sb.pop_front();
      n_vec++;
      if ((e.cyc != cyc) || (state !== e.st) || (cmd_output !== e.cmd) ||
          ({motor_en, pid_rst, fault} !== flags_for(e.st))) begin
        n_bad++;
        $display("FAIL %s @cyc %0d (due %0d): state=%0d cmd=%0d me/pr/flt=%b, required state=%0d cmd=%0d me/pr/flt=%b",
                 e.name, cyc, e.cyc, state, cmd_output, {motor_en, pid_rst, fault},
                 e.st, e.cmd, flags_for(e.st));
      end
    end
  end

  int a, d, s, f, g, h, a2, a3, p;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; sensor = 4'b0110; pid_output = '0;
    tick();
    n_vec++;
    if ((state !== 3'(IDLE)) || (pid_rst !== 1'b1)) begin
      n_bad++;
      $display("FAIL in_reset: state=%0d pid_rst=%b", state, pid_rst);
    end
    expect_at(cyc + 1, "reset_a", IDLE, 0);
    expect_at(cyc + 2, "reset_b", IDLE, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Arm dwell
    start = 1'b1; a = cyc;
    expect_at(a + 1,  "arm_entry",    ARM,    0);
    expect_at(a + 12, "arm_dwell",    ARM,    0);
    expect_at(a + 13, "follow_entry", FOLLOW, 0);
    wait_until(a + 13);
    n_vec++;
    if ((state !== 3'(FOLLOW)) || (motor_en !== 1'b1) || (pid_rst !== 1'b0)) begin
      n_bad++;
      $display("FAIL follow_direct: state=%0d motor_en=%b pid_rst=%b", state, motor_en, pid_rst);
    end

    // Passthrough
    pid_output = -11'sd57;
    expect_at(cyc + 1, "pass_neg", FOLLOW, -57);
    tick();
    n_vec++;
    if (cmd_output !== -11'sd57) begin
      n_bad++;
      $display("FAIL pass_neg_direct: cmd=%0d", cmd_output);
    end
    pid_output = 11'sd200;
    expect_at(cyc + 1, "pass_pos", FOLLOW, 200);
    tick();

    // Right-side sighting, then loss with a glitch at zero-cycle 5
    sensor = 4'b0001;
    tick();
    sensor = 4'b0000; d = cyc;
    expect_at(d + 8,  "glitch_hold", FOLLOW, 200);
    expect_at(d + 12, "glitch_pre",  FOLLOW, 200);
    expect_at(d + 13, "lost_right",  SEARCH, 300);
    wait_until(d + 4);
    sensor = 4'b0010;
    tick();
    sensor = 4'b0000;

    // Reacquire at search cycle 10
    s = d + 13;
    wait_until(s + 9);
    sensor = 4'b1000;
    expect_at(s + 9,  "search_hold", SEARCH, 300);
    expect_at(s + 10, "reacquire",   FOLLOW, 200);

    // Clean loss (left memory), then search timeout into HALT
    wait_until(s + 11);
    sensor = 4'b0000; f = cyc;
    expect_at(f + 7, "lost_pre",  FOLLOW, 200);
    expect_at(f + 8, "lost_left", SEARCH, -300);
    g = f + 8;
    expect_at(g + 19, "search_long", SEARCH, -300);
    expect_at(g + 20, "halt",        HALT,   0);

    // HALT holds with start high; re-press exits to ARM
    h = g + 20;
    expect_at(h + 3, "halt_held", HALT, 0);
    wait_until(h + 3);
    n_vec++;
    if ((state !== 3'(HALT)) || (fault !== 1'b1) || (motor_en !== 1'b0) ||
        (cmd_output !== 11'sd0)) begin
      n_bad++;
      $display("FAIL halt_direct: state=%0d fault=%b motor_en=%b cmd=%0d",
               state, fault, motor_en, cmd_output);
    end
    start = 1'b0;
    tick();
    start = 1'b1;
    expect_at(h + 4, "halt_pre_exit", HALT, 0);
    expect_at(h + 5, "halt_exit",     ARM,  0);

    // Stop mid-ARM, then a fresh full-length arm
    a2 = h + 5;
    wait_until(a2 + 4);
    stop = 1'b1;
    expect_at(a2 + 4, "arm_before_stop", ARM,  0);
    expect_at(a2 + 5, "stop_in_arm",     IDLE, 0);
    tick();
    stop = 1'b0; start = 1'b0; sensor = 4'b0110;
    expect_at(a2 + 6, "idle_after_stop", IDLE, 0);
    tick();
    start = 1'b1; a3 = cyc;
    expect_at(a3 + 1,  "rearm",       ARM,    0);
    expect_at(a3 + 12, "rearm_dwell", ARM,    0);
    expect_at(a3 + 13, "refollow",    FOLLOW, 200);

    // Back to HALT, then stop and start edge together
    p = a3 + 13;
    wait_until(p);
    sensor = 4'b0000;
    expect_at(p + 28, "halt_again", HALT, 0);
    wait_until(p + 28);
    start = 1'b0;
    tick();
    start = 1'b1; stop = 1'b1;
    expect_at(p + 29, "halt_pre_stop",   HALT, 0);
    expect_at(p + 30, "stop_over_start", IDLE, 0);
    tick();
    stop = 1'b0;
    expect_at(p + 32, "idle_no_edge", IDLE, 0);
    wait_until(p + 33);
    n_vec++;
    if ((state !== 3'(IDLE)) || (fault !== 1'b0)) begin
      n_bad++;
      $display("FAIL idle_direct: state=%0d fault=%b", state, fault);
    end

    for (int i = 0; (i < 20) && (sb.size() > 0); i++) tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL %s: never checked, required state=%0d cmd=%0d", e.name, e.st, e.cmd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
